// File: rtl/fft_output_stream_if.sv
// Frame-in / bin-stream-out bundle shared by the FFT output serialiser and its producer/consumer.
interface fft_output_stream_if #(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned NPOINT = 8
);
  localparam int unsigned IDXW = $clog2(NPOINT);

  logic [NPOINT*WIDTH-1:0] in_re;
  logic [NPOINT*WIDTH-1:0] in_im;
  logic                    in_valid;
  logic                    in_ready;
  logic [WIDTH-1:0]        output_re;
  logic [WIDTH-1:0]        output_im;
  logic [IDXW-1:0]         output_idx;
  logic                    output_valid;
  logic                    output_last;
  logic                    busy;

  modport master (
    output in_re, in_im, in_valid,
    input  in_ready, output_re, output_im, output_idx, output_valid, output_last, busy
  );

  modport slave (
    input  in_re, in_im, in_valid,
    output in_ready, output_re, output_im, output_idx, output_valid, output_last, busy
  );
endinterface

// File: rtl/fft_output_stream.sv
// Serialises one captured N-point complex frame into one bin per DIV fastclk cycles,
// with a one-frame hold buffer so back-to-back frames stream without a gap.
module fft_output_stream #(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned NPOINT     = 8,
  parameter int unsigned DIV        = 25,
  parameter int unsigned REAL_INPUT = 1
) (
  input logic               fastclk,
  input logic               rst,
  fft_output_stream_if.slave bus
);
  localparam int unsigned IDXW = $clog2(NPOINT);
  localparam int unsigned DIVW = $clog2(DIV);

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NPOINT - 1);
  localparam logic [IDXW-1:0] IDX_HALF = IDXW'(NPOINT / 2);
  localparam logic [DIVW-1:0] DIV_LAST = DIVW'(DIV - 1);

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t           state_q;
  logic [DIVW-1:0]  div_q;
  logic [IDXW-1:0]  idx_q;
  logic             hold_full_q;
  logic [WIDTH-1:0] hold_re_q [NPOINT];
  logic [WIDTH-1:0] hold_im_q [NPOINT];
  logic [WIDTH-1:0] act_re_q  [NPOINT];
  logic [WIDTH-1:0] act_im_q  [NPOINT];
  logic [WIDTH-1:0] out_re_q;
  logic [WIDTH-1:0] out_im_q;
  logic [IDXW-1:0]  out_idx_q;
  logic             out_valid_q;
  logic             out_last_q;

  logic [WIDTH-1:0] in_re_a [NPOINT];
  logic [WIDTH-1:0] in_im_a [NPOINT];
  logic [WIDTH-1:0] bin_re;
  logic [WIDTH-1:0] bin_im;
  logic             accept;

  for (genvar k = 0; k < NPOINT; k++) begin : g_unpack
    assign in_re_a[k] = bus.in_re[k*WIDTH +: WIDTH];
    assign in_im_a[k] = bus.in_im[k*WIDTH +: WIDTH];
  end

  assign bus.in_ready = !hold_full_q && !rst;
  assign accept       = bus.in_valid && bus.in_ready;

  // Current bin; a real-input transform has purely real DC and Nyquist bins.
  always_comb begin
    bin_re = act_re_q[idx_q];
    bin_im = act_im_q[idx_q];
    if ((REAL_INPUT != 0) && ((idx_q == '0) || (idx_q == IDX_HALF))) begin
      bin_im = '0;
    end
  end

  always_ff @(posedge fastclk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      div_q       <= '0;
      idx_q       <= '0;
      hold_full_q <= 1'b0;
      hold_re_q   <= '{default: '0};
      hold_im_q   <= '{default: '0};
      act_re_q    <= '{default: '0};
      act_im_q    <= '{default: '0};
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_idx_q   <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;

      // in_ready excludes a full hold buffer, so this never collides with a transfer below.
      if (accept) begin
        hold_re_q   <= in_re_a;
        hold_im_q   <= in_im_a;
        hold_full_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            act_re_q    <= hold_re_q;
            act_im_q    <= hold_im_q;
            hold_full_q <= 1'b0;
            div_q       <= '0;
            idx_q       <= '0;
            state_q     <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (div_q == DIV_LAST) begin
            div_q       <= '0;
            out_re_q    <= bin_re;
            out_im_q    <= bin_im;
            out_idx_q   <= idx_q;
            out_valid_q <= 1'b1;
            out_last_q  <= (idx_q == IDX_LAST);
            if (idx_q != IDX_LAST) begin
              idx_q <= idx_q + 1'b1;
            end else if (hold_full_q) begin
              // Gapless hand-over to the frame waiting in the hold buffer.
              act_re_q    <= hold_re_q;
              act_im_q    <= hold_im_q;
              hold_full_q <= 1'b0;
              idx_q       <= '0;
            end else begin
              state_q <= ST_IDLE;
            end
          end else begin
            div_q <= div_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.output_re    = out_re_q;
  assign bus.output_im    = out_im_q;
  assign bus.output_idx   = out_idx_q;
  assign bus.output_valid = out_valid_q;
  assign bus.output_last  = out_last_q;
  assign bus.busy         = (state_q == ST_RUN);
endmodule

// File: tb/tb_fft_output_stream.sv
// Scoreboard bench for fft_output_stream: a REAL_INPUT=1 and a REAL_INPUT=0 instance
// fed identical frames, WIDTH=8, NPOINT=8, DIV=4.
module tb_fft_output_stream;
  localparam int unsigned W  = 8;
  localparam int unsigned NP = 8;
  localparam int unsigned DV = 4;

  typedef struct {
    logic [7:0] re      [NP];
    logic [7:0] im      [NP];
    logic [7:0] exp_im1 [NP];
  } vec_t;

  typedef struct {
    logic [7:0] re;
    logic [7:0] im;
    logic [2:0] idx;
    logic       last;
  } sb_t;

  logic fastclk = 1'b0;
  logic rst     = 1'b1;
  int   cyc     = 0;

  int n_vec = 0;
  int n_err = 0;

  vec_t tab [7];
  sb_t  q1 [$];
  sb_t  q0 [$];
  int   strobe_log [$];
  int   busy_log   [$];

  fft_output_stream_if #(.WIDTH(W), .NPOINT(NP)) bus1 ();
  fft_output_stream_if #(.WIDTH(W), .NPOINT(NP)) bus0 ();

  fft_output_stream #(.WIDTH(W), .NPOINT(NP), .DIV(DV), .REAL_INPUT(1)) dut1 (
    .fastclk(fastclk), .rst(rst), .bus(bus1.slave)
  );
  fft_output_stream #(.WIDTH(W), .NPOINT(NP), .DIV(DV), .REAL_INPUT(0)) dut0 (
    .fastclk(fastclk), .rst(rst), .bus(bus0.slave)
  );

  always #5 fastclk = ~fastclk;
  always @(posedge fastclk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard: every strobe must match the next expected bin of its instance.
  always @(negedge fastclk) begin
    sb_t e;
    if (bus1.output_valid === 1'b1) begin
      strobe_log.push_back(cyc);
      busy_log.push_back(int'(bus1.busy));
      if (q1.size() == 0) begin
        chk("unexpected_strobe_r1", 32'(bus1.output_idx), 32'hFFFF);
      end else begin
        e = q1.pop_front();
        chk("re_r1",   32'(bus1.output_re),   32'(e.re));
        chk("im_r1",   32'(bus1.output_im),   32'(e.im));
        chk("idx_r1",  32'(bus1.output_idx),  32'(e.idx));
        chk("last_r1", 32'(bus1.output_last), 32'(e.last));
      end
    end else if (bus1.output_last !== 1'b0) begin
      chk("last_without_valid_r1", 32'(bus1.output_last), 32'd0);
    end
    if (bus0.output_valid === 1'b1) begin
      if (q0.size() == 0) begin
        chk("unexpected_strobe_r0", 32'(bus0.output_idx), 32'hFFFF);
      end else begin
        e = q0.pop_front();
        chk("re_r0",   32'(bus0.output_re),   32'(e.re));
        chk("im_r0",   32'(bus0.output_im),   32'(e.im));
        chk("idx_r0",  32'(bus0.output_idx),  32'(e.idx));
        chk("last_r0", 32'(bus0.output_last), 32'(e.last));
      end
    end
  end

  function automatic void push_exp(input int v);
    sb_t e;
    for (int k = 0; k < int'(NP); k++) begin
      e.re   = tab[v].re[k];
      e.idx  = 3'(k);
      e.last = (k == int'(NP) - 1);
      e.im   = tab[v].exp_im1[k];
      q1.push_back(e);
      e.im   = tab[v].im[k];
      q0.push_back(e);
    end
  endfunction

  task automatic send(input int v, output int acc);
    int waited = 0;
    while (bus1.in_ready !== 1'b1 && waited < 200) begin
      @(negedge fastclk);
      waited++;
    end
    if (bus1.in_ready !== 1'b1) begin
      chk("send_timeout", 32'(bus1.in_ready), 32'd1);
      acc = -1;
    end else begin
      for (int k = 0; k < int'(NP); k++) begin
        bus1.in_re[k*W +: W] = tab[v].re[k];
        bus1.in_im[k*W +: W] = tab[v].im[k];
        bus0.in_re[k*W +: W] = tab[v].re[k];
        bus0.in_im[k*W +: W] = tab[v].im[k];
      end
      bus1.in_valid = 1'b1;
      bus0.in_valid = 1'b1;
      @(posedge fastclk);
      #1;
      acc = cyc;
      bus1.in_valid = 1'b0;
      bus0.in_valid = 1'b0;
      push_exp(v);
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 400) begin
      @(negedge fastclk);
      #2;
      n++;
    end
    if (q1.size() != 0 || q0.size() != 0) begin
      chk({name, "_drain_timeout"}, 32'(q1.size()), 32'd0);
      q1.delete();
      q0.delete();
    end
  endtask

  task automatic chk_idle_outputs(input string name);
    chk({name, "_re"},    32'(bus1.output_re),    32'd0);
    chk({name, "_im"},    32'(bus1.output_im),    32'd0);
    chk({name, "_idx"},   32'(bus1.output_idx),   32'd0);
    chk({name, "_valid"}, 32'(bus1.output_valid), 32'd0);
    chk({name, "_last"},  32'(bus1.output_last),  32'd0);
    chk({name, "_busy"},  32'(bus1.busy),         32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc_a, acc_b, acc_c, acc_d, acc_e;

    for (int k = 0; k < int'(NP); k++) begin
      tab[0].re[k] = 8'(8'h10 + k);
      tab[0].im[k] = 8'(8'h20 + k);
    end
    tab[0].exp_im1 = '{8'h00, 8'h21, 8'h22, 8'h23, 8'h00, 8'h25, 8'h26, 8'h27};
    tab[1].re      = '{8'h80, 8'hFF, 8'h7F, 8'h01, 8'hFE, 8'h81, 8'h00, 8'hC3};
    tab[1].im      = '{8'hFF, 8'h80, 8'hFF, 8'h80, 8'h7E, 8'h01, 8'hFF, 8'h80};
    tab[1].exp_im1 = '{8'h00, 8'h80, 8'hFF, 8'h80, 8'h00, 8'h01, 8'hFF, 8'h80};
    for (int v = 2; v < 7; v++) begin
      for (int k = 0; k < int'(NP); k++) begin
        tab[v].re[k]      = 8'($urandom_range(0, 255));
        tab[v].im[k]      = 8'($urandom_range(0, 255));
        tab[v].exp_im1[k] = (k == 0 || k == int'(NP) / 2) ? 8'h00 : tab[v].im[k];
      end
    end

    bus1.in_re = '0; bus1.in_im = '0; bus1.in_valid = 1'b0;
    bus0.in_re = '0; bus0.in_im = '0; bus0.in_valid = 1'b0;

    // Reset: in_ready low during reset, high right after release.
    repeat (3) @(negedge fastclk);
    chk("rst_in_ready", 32'(bus1.in_ready), 32'd0);
    chk_idle_outputs("rst");
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", 32'(bus1.in_ready), 32'd1);
    chk_idle_outputs("post_rst");

    // Single frame: strobes on E+5, E+9, ..., E+33; busy drops with the last strobe.
    @(negedge fastclk);
    strobe_log.delete(); busy_log.delete();
    send(0, acc_a);
    wait_drain("single");
    chk("single_busy_after_last", 32'(bus1.busy), 32'd0);
    chk("single_nstrobes", 32'(strobe_log.size()), 32'd8);
    if (strobe_log.size() == 8) begin
      for (int i = 0; i < 8; i++) chk("single_strobe_cycle", 32'(strobe_log[i]), 32'(acc_a + 5 + 4*i));
    end

    // Negative / extreme values, bit-exact.
    repeat (3) @(negedge fastclk);
    send(1, acc_a);
    wait_drain("negative");

    // Back-to-back A, B, then C refused until B transfers.
    repeat (3) @(negedge fastclk);
    strobe_log.delete(); busy_log.delete();
    send(2, acc_a);
    send(3, acc_b);
    chk("b2b_in_ready_low_after_b", 32'(bus1.in_ready), 32'd0);
    send(4, acc_c);
    wait_drain("b2b");
    chk("b2b_nstrobes", 32'(strobe_log.size()), 32'd24);
    if (strobe_log.size() == 24) begin
      chk("b2b_first_strobe",  32'(strobe_log[0]),  32'(acc_a + 5));
      chk("b2b_gap_a_b",       32'(strobe_log[8] - strobe_log[7]),   32'(DV));
      chk("b2b_gap_b_c",       32'(strobe_log[16] - strobe_log[15]), 32'(DV));
      chk("b2b_c_accept",      32'(acc_c),        32'(strobe_log[7] + 1));
      chk("b2b_busy_boundary", 32'(busy_log[7]),  32'd1);
    end

    // Accept on the same edge as the last emit with hold empty: one IDLE cycle.
    repeat (3) @(negedge fastclk);
    strobe_log.delete(); busy_log.delete();
    send(5, acc_d);
    while (cyc < acc_d + 32) @(negedge fastclk);
    send(6, acc_e);
    wait_drain("boundary");
    chk("bnd_nstrobes", 32'(strobe_log.size()), 32'd16);
    if (strobe_log.size() == 16) begin
      chk("bnd_accept_on_last", 32'(acc_e),       32'(strobe_log[7]));
      chk("bnd_idle_busy",      32'(busy_log[7]), 32'd0);
      chk("bnd_gap",            32'(strobe_log[8] - strobe_log[7]), 32'(DV + 1));
      chk("bnd_period",         32'(strobe_log[9] - strobe_log[8]), 32'(DV));
    end

    // Reset while output_idx == 3.
    repeat (3) @(negedge fastclk);
    strobe_log.delete(); busy_log.delete();
    send(2, acc_a);
    while (strobe_log.size() < 4 && cyc < acc_a + 100) begin
      @(negedge fastclk);
      #2;
    end
    chk("mid_idx_before_rst", 32'(bus1.output_idx), 32'd3);
    rst = 1'b1;
    #1;
    chk_idle_outputs("mid_rst");
    chk("mid_rst_in_ready", 32'(bus1.in_ready), 32'd0);
    q1.delete(); q0.delete();
    strobe_log.delete(); busy_log.delete();
    repeat (2) @(negedge fastclk);
    rst = 1'b0;
    repeat (40) @(negedge fastclk);
    chk("mid_no_strobes", 32'(strobe_log.size()), 32'd0);
    send(3, acc_b);
    wait_drain("after_rst");
    chk("after_rst_nstrobes", 32'(strobe_log.size()), 32'd8);
    if (strobe_log.size() == 8) chk("after_rst_first", 32'(strobe_log[0]), 32'(acc_b + 5));

    repeat (5) @(negedge fastclk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
